// File: rtl/strobe_period_meter.sv
// Strobe period meter: counts enable-qualified ticks between strobes, publishes through a
// one-entry valid/ready register. Optional min/max tracking: STROBE_PERIOD_METER_MINMAX_EN.
module strobe_period_meter #(
  parameter int unsigned WIDTH = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             strobe_in,
  input  logic [WIDTH-1:0] timeout_value,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  input  logic             period_ready,
  output logic             saturated,
  output logic             overrun,
  output logic             timeout,
  output logic [WIDTH-1:0] period_min,
  output logic [WIDTH-1:0] period_max
);

  typedef enum logic [0:0] {StIdle, StMeasure} state_t;

  localparam logic [WIDTH-1:0] AllOnes = '1;
  localparam logic [WIDTH-1:0] One     = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_next;
  logic             publish;
  logic             tmo_hit;

  // Saturating increment: the count sticks at all-ones instead of wrapping.
  always_comb begin
    cnt_next = cnt;
    if (enable && (cnt != AllOnes)) begin
      cnt_next = cnt + One;
    end
  end

  assign publish = (state == StMeasure) && strobe_in;
  assign tmo_hit = (state == StMeasure) && !strobe_in && (timeout_value != '0) &&
                   (cnt_next == timeout_value);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= StIdle;
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      saturated    <= 1'b0;
      overrun      <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      overrun <= 1'b0;
      timeout <= 1'b0;

      unique case (state)
        StIdle: begin
          cnt <= '0;
          if (strobe_in) begin
            state <= StMeasure;
          end
        end
        StMeasure: begin
          if (strobe_in) begin
            cnt <= '0;
          end else if (tmo_hit) begin
            timeout <= 1'b1;
            state   <= StIdle;
            cnt     <= '0;
          end else begin
            cnt <= cnt_next;
          end
        end
        default: begin
          state <= StIdle;
          cnt   <= '0;
        end
      endcase

      // A publish wins over a same-cycle transfer; overrun only if the old value was not taken.
      if (publish) begin
        period       <= cnt_next;
        saturated    <= (cnt_next == AllOnes);
        period_valid <= 1'b1;
        overrun      <= period_valid && !period_ready;
      end else if (period_valid && period_ready) begin
        period_valid <= 1'b0;
      end
    end
  end

`ifdef STROBE_PERIOD_METER_MINMAX_EN
  logic [WIDTH-1:0] min_q;
  logic [WIDTH-1:0] max_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      min_q <= AllOnes;
      max_q <= '0;
    end else if (publish) begin
      if (cnt_next == AllOnes) begin
        max_q <= AllOnes;
      end else begin
        if (cnt_next < min_q) min_q <= cnt_next;
        if (cnt_next > max_q) max_q <= cnt_next;
      end
    end
  end

  assign period_min = min_q;
  assign period_max = max_q;
`else
  assign period_min = '0;
  assign period_max = '0;
`endif

endmodule
